mem_access_controller: RTL and testbench

MEM-stage sequencer between the pipeline's memory control signals (Mem_Read, Mem_Write, Store_Byte) and a single-port, word-wide data memory with a ready/ack handshake. It stalls the pipeline for the whole duration of each access. Byte stores are performed as a read-modify-write sequence. Misaligned word accesses, read/write conflicts and memory timeouts are flagged on an error output.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/byte_lane_merge.sv | 24 ++
 rtl/mem_access_controller.sv | 169 ++++++++++++++++
 tb/tb_mem_access_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StSbRead,
    StSbWrite,
    StDone
  } state_e;

  localparam int unsigned LANE_W = 8;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

endpackage

// File: rtl/byte_lane_merge.sv
// Replaces one little-endian byte lane of a word with a new byte.
module byte_lane_merge
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [LANE_W-1:0] byte_val,
  input  logic [1:0]        lane,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = word;
    unique case (lane)
      LANE_0: merged[0*LANE_W +: LANE_W] = byte_val;
      LANE_1: merged[1*LANE_W +: LANE_W] = byte_val;
      LANE_2: merged[2*LANE_W +: LANE_W] = byte_val;
      LANE_3: merged[3*LANE_W +: LANE_W] = byte_val;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/mem_access_controller.sv
// MEM-stage sequencer: stalls the pipeline around single-port memory accesses,
// performs byte stores as read-modify-write and flags misalignment/conflict/timeout.
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_mem_read,
  input  logic              req_mem_write,
  input  logic              req_store_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [LANE_W-1:0] byte_q, byte_d;
  logic [1:0]        lane_q, lane_d;
  logic              err_q, err_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              timeout;
  logic              req_any;
  logic [DATA_W-1:0] merged_word;

  byte_lane_merge #(
    .DATA_W(DATA_W)
  ) u_merge (
    .word    (mem_rdata),
    .byte_val(byte_q),
    .lane    (lane_q),
    .merged  (merged_word)
  );

  assign req_any = req_mem_read | req_mem_write;
  assign timeout = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    byte_d  = byte_q;
    lane_d  = lane_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          addr_d = {req_addr[ADDR_W-1:2], 2'b00};
          byte_d = req_wdata[LANE_W-1:0];
          lane_d = req_addr[1:0];
          // A simultaneous read is dropped in favour of the write but still reported.
          err_d  = req_mem_read & req_mem_write;
          if (req_mem_write && req_store_byte) begin
            state_d = StSbRead;
          end else if (req_addr[1:0] != 2'b00) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else if (req_mem_write) begin
            state_d = StWrite;
            wdata_d = req_wdata;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack) begin
          load_d  = mem_rdata;
          state_d = StDone;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StSbRead: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack) begin
          wdata_d = merged_word;
          cnt_d   = '0;
          state_d = StSbWrite;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StWrite, StSbWrite: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack) begin
          state_d = StDone;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Strobes are registered from the next state so they track state entry/exit exactly.
    re_d = (state_d == StRead) || (state_d == StSbRead);
    we_d = (state_d == StWrite) || (state_d == StSbWrite);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      byte_q  <= '0;
      lane_q  <= '0;
      err_q   <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      byte_q  <= byte_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
      re_q    <= re_d;
      we_q    <= we_d;
    end
  end

  assign stall = ((state_q == StIdle) && req_any) ||
                 (state_q == StRead) || (state_q == StWrite) ||
                 (state_q == StSbRead) || (state_q == StSbWrite);
  assign done      = (state_q == StDone);
  assign err       = (state_q == StDone) && err_q;
  assign load_data = load_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench: directed and random accesses against a transaction-level model.
module tb_mem_access_controller;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_mem_read, req_mem_write, req_store_byte;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, err;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, mem_ack;

  always #5 clk = ~clk;

  mem_access_controller #(
    .DATA_W (32),
    .ADDR_W (32),
    .TIMEOUT(T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_mem_read  (req_mem_read),
    .req_mem_write (req_mem_write),
    .req_store_byte(req_store_byte),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .stall         (stall),
    .done          (done),
    .err           (err),
    .load_data     (load_data),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack)
  );

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] model_load;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: the bench plays the memory (ack after d1/d2 wait cycles per strobe)
  // and compares what it saw with the transaction-level expectation.
  task automatic access(input string tag, input logic rd, input logic wr, input logic sb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int d1, input int d2);
    int st_c = 0, re_c = 0, we_c = 0, done_c = 0, unstable = 0, addr_bad = 0, pcnt = 0;
    int cyc = 0, e_st, e_re, e_we, sh, idx;
    logic err_at_done = 1'b0, prev_re = 1'b0, prev_we = 1'b0, seen_done = 1'b0, e_err;
    logic sbyte, mis;
    logic [31:0] s_addr = '0, s_wdata = '0, e_word, e_load;

    idx   = int'(addr[7:2]);
    sh    = 8 * int'(addr[1:0]);
    sbyte = wr && sb;
    mis   = !sbyte && (addr[1:0] != 2'd0);
    e_word = ref_mem[idx];
    e_load = model_load;
    e_err  = rd && wr;
    e_re   = 0;
    e_we   = 0;
    if (mis) begin
      e_err = 1'b1;
    end else if (sbyte) begin
      if (d1 >= int'(T)) begin
        e_re = T; e_err = 1'b1;
      end else begin
        e_re = d1 + 1;
        if (d2 >= int'(T)) begin
          e_we = T; e_err = 1'b1;
        end else begin
          e_we = d2 + 1;
          e_word = (e_word & ~(32'hFF << sh)) | ({24'd0, wdata[7:0]} << sh);
        end
      end
    end else if (wr) begin
      if (d1 >= int'(T)) begin e_we = T; e_err = 1'b1; end
      else begin e_we = d1 + 1; e_word = wdata; end
    end else begin
      if (d1 >= int'(T)) begin e_re = T; e_err = 1'b1; end
      else begin e_re = d1 + 1; e_load = e_word; end
    end
    e_st = 1 + e_re + e_we;

    req_mem_read = rd; req_mem_write = wr; req_store_byte = sb;
    req_addr = addr; req_wdata = wdata;
    while (!seen_done && cyc < 200) begin
      #1;
      if (stall) st_c++;
      if (done) begin done_c++; err_at_done = err; seen_done = 1'b1; end
      mem_ack   = 1'b0;
      mem_rdata = $urandom();
      if (mem_re || mem_we) begin
        if ((mem_re && !prev_re) || (mem_we && !prev_we)) begin
          pcnt = 0; s_addr = mem_addr; s_wdata = mem_wdata;
          if (mem_addr !== {addr[31:2], 2'b00}) addr_bad++;
        end else begin
          pcnt++;
          if (mem_addr !== s_addr || (mem_we && mem_wdata !== s_wdata)) unstable++;
        end
        if (mem_re) re_c++;
        if (mem_we) we_c++;
        if (pcnt == ((mem_we && sbyte) ? d2 : d1)) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr[7:2]];
          if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
        end
      end
      prev_re = mem_re;
      prev_we = mem_we;
      @(posedge clk);
      cyc++;
    end
    req_mem_read = 1'b0; req_mem_write = 1'b0; req_store_byte = 1'b0;
    mem_ack = 1'b0;
    #1;
    if (stall) st_c++;
    if (done) done_c++;
    @(posedge clk);
    #1;
    if (stall) st_c++;
    if (done) done_c++;

    check({tag, ":stall_cycles"}, 32'(st_c), 32'(e_st));
    check({tag, ":re_cycles"}, 32'(re_c), 32'(e_re));
    check({tag, ":we_cycles"}, 32'(we_c), 32'(e_we));
    check({tag, ":done_pulses"}, 32'(done_c), 32'd1);
    check({tag, ":err"}, 32'(err_at_done), 32'(e_err));
    check({tag, ":load_data"}, load_data, e_load);
    check({tag, ":mem_word"}, mem[idx], e_word);
    check({tag, ":unstable"}, 32'(unstable), 32'd0);
    check({tag, ":addr_bad"}, 32'(addr_bad), 32'd0);
    ref_mem[idx] = e_word;
    model_load   = e_load;
  endtask

  initial begin
    logic rd, wr, sb;
    int d1, d2;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom();
      ref_mem[i] = mem[i];
    end
    model_load = '0;
    rst = 1'b1;
    req_mem_read = 1'b0; req_mem_write = 1'b0; req_store_byte = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:stall", 32'(stall), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:err", 32'(err), 32'd0);
    check("rst:load_data", load_data, 32'd0);
    check("rst:mem_re", 32'(mem_re), 32'd0);
    check("rst:mem_we", 32'(mem_we), 32'd0);
    check("rst:mem_addr", mem_addr, 32'd0);
    check("rst:mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    access("load", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 0, 0);
    mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
    access("sb", 1'b0, 1'b1, 1'b1, 32'h22, 32'h000000AB, 0, 0);
    check("sb:merged_word", mem[8], 32'h11AB3344);
    access("sw_delay3", 1'b0, 1'b1, 1'b0, 32'h30, 32'hCAFEF00D, 3, 0);
    access("load_timeout", 1'b1, 1'b0, 1'b0, 32'h14, 32'h0, T + 4, 0);
    access("misaligned_rd", 1'b1, 1'b0, 1'b0, 32'h13, 32'h0, 0, 0);
    access("misaligned_wr", 1'b0, 1'b1, 1'b0, 32'h42, 32'h55667788, 0, 0);
    access("rd_wr_conflict", 1'b1, 1'b1, 1'b0, 32'h40, 32'h12345678, 0, 0);
    access("sb_rd_timeout", 1'b0, 1'b1, 1'b1, 32'h51, 32'h000000EE, T, 0);
    access("sb_wr_timeout", 1'b0, 1'b1, 1'b1, 32'h57, 32'h000000DD, 1, T + 2);
    access("sb_lane0", 1'b0, 1'b1, 1'b1, 32'h60, 32'hFFFFFF12, 2, 1);
    access("sb_lane3", 1'b0, 1'b1, 1'b1, 32'h63, 32'h00000034, 0, 2);

    // Reset while the byte-store write strobe is waiting for ack.
    mem[9] = 32'hA5A5A5A5; ref_mem[9] = 32'hA5A5A5A5;
    req_mem_write = 1'b1; req_store_byte = 1'b1; req_addr = 32'h25; req_wdata = 32'h77;
    @(posedge clk);
    #1;
    check("rst_mid:re", 32'(mem_re), 32'd1);
    mem_ack = 1'b1; mem_rdata = mem[9];
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("rst_mid:we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_mem_write = 1'b0; req_store_byte = 1'b0;
    #1;
    check("rst_mid:we_after", 32'(mem_we), 32'd0);
    check("rst_mid:re_after", 32'(mem_re), 32'd0);
    check("rst_mid:stall", 32'(stall), 32'd0);
    check("rst_mid:done", 32'(done), 32'd0);
    check("rst_mid:load_data", load_data, 32'd0);
    check("rst_mid:mem_word", mem[9], ref_mem[9]);
    model_load = '0;
    @(posedge clk);
    #1;

    for (int n = 0; n < 80; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      d1 = ($urandom_range(0, 9) == 0) ? int'(T) + int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, 3));
      d2 = ($urandom_range(0, 9) == 0) ? int'(T) + int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, 3));
      access("rand", rd, wr, sb, 32'($urandom_range(0, 255)), $urandom(), d1, d2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
